// File: rtl/popcount_pipe.sv
// Pipelined population count with optional multi-beat accumulation.
// Stage 1 counts bits per nibble and folds nibble pairs, stage 2 reduces the
// partials to a beat count, and the output stage applies standalone or
// accumulate/saturate handling under a two-state FSM. The whole pipeline
// advances together on en = !out_valid || out_ready.
module popcount_pipe #(
    parameter int WIDTH = 40,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_count,
    output logic             out_sat
);

    localparam int NIB   = WIDTH / 4;
    localparam int PAIRS = (NIB + 1) / 2;
    localparam int PAD_W = PAIRS * 8;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int SW    = OUT_W + 1;
    localparam logic [SW-1:0] SAT_MAX = {1'b0, {OUT_W{1'b1}}};

    // Reject illegal parameterisations at elaboration time.
    if (WIDTH < 4 || WIDTH > 256 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("popcount_pipe: WIDTH must be in 4..256 and a multiple of 4");
    end
    if (OUT_W < CW) begin : g_bad_out_w
        $error("popcount_pipe: OUT_W too narrow to hold a full beat count");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // 4-bit lookup popcount.
    function automatic logic [2:0] nib_pop(input logic [3:0] n);
        logic [2:0] r;
        unique case (n)
            4'h0:                                     r = 3'd0;
            4'h1, 4'h2, 4'h4, 4'h8:                   r = 3'd1;
            4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC:       r = 3'd2;
            4'h7, 4'hB, 4'hD, 4'hE:                   r = 3'd3;
            default:                                  r = 3'd4;
        endcase
        return r;
    endfunction

    logic en;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic             s1_acc_q,   s1_acc_d;
    logic             s1_last_q,  s1_last_d;
    logic [3:0]       s1_pair_q [PAIRS];
    logic [3:0]       s1_pair_d [PAIRS];
    logic [PAD_W-1:0] mask_pad;

    // Stage 2 registers
    logic          s2_valid_q, s2_valid_d;
    logic          s2_acc_q,   s2_acc_d;
    logic          s2_last_q,  s2_last_d;
    logic [CW-1:0] s2_cnt_q,   s2_cnt_d;
    logic [CW-1:0] beat_cnt;

    // Output stage, accumulator and FSM
    state_e           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_count_q, out_count_d;
    logic             out_sat_q, out_sat_d;
    logic [OUT_W-1:0] acc_base;
    logic             sticky_base;
    logic [SW-1:0]    acc_sum;
    logic             clip;
    logic [OUT_W-1:0] acc_sat;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

    // Zero-pad the mask so an odd nibble count still forms whole pairs.
    assign mask_pad = PAD_W'(in_mask);

    // Stage 1 next state: nibble LUT counts folded pairwise; controls ride along.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        s1_valid_d = s1_valid_q;
        s1_acc_d   = s1_acc_q;
        s1_last_d  = s1_last_q;
        s1_pair_d  = s1_pair_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_acc_d   = in_acc;
            s1_last_d  = in_last;
            for (int p = 0; p < PAIRS; p++) begin
                s1_pair_d[p] = {1'b0, nib_pop(mask_pad[8*p +: 4])}
                             + {1'b0, nib_pop(mask_pad[8*p+4 +: 4])};
            end
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!RST) begin
            s1_valid_q <= 1'b0;
            s1_acc_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            for (int p = 0; p < PAIRS; p++) s1_pair_q[p] <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_acc_q   <= s1_acc_d;
            s1_last_q  <= s1_last_d;
            s1_pair_q  <= s1_pair_d;
        end
    end

    // Stage 2 reduction of the pair partials to the full beat count.
    always_comb begin
        beat_cnt = '0;
        for (int p = 0; p < PAIRS; p++) begin
            beat_cnt = beat_cnt + CW'(s1_pair_q[p]);
        end
    end

    // Stage 2 next state: capture the beat count and its controls.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_acc_d   = s2_acc_q;
        s2_last_d  = s2_last_q;
        s2_cnt_d   = s2_cnt_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_acc_d   = s1_acc_q;
            s2_last_d  = s1_last_q;
            s2_cnt_d   = beat_cnt;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            s2_valid_q <= 1'b0;
            s2_acc_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_cnt_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_acc_q   <= s2_acc_d;
            s2_last_q  <= s2_last_d;
            s2_cnt_q   <= s2_cnt_d;
        end
    end

    // FSM next state and output stage: standalone, accumulate or close.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        // With no open accumulation the running sum starts from zero.
        acc_base    = (state_q == ACCUM) ? acc_q : '0;
        sticky_base = (state_q == ACCUM) ? sticky_q : 1'b0;

        // One bit wider than the result so the clip test never sees a wrap.
        acc_sum = {1'b0, acc_base} + SW'(s2_cnt_q);
        clip    = acc_sum > SAT_MAX;
        acc_sat = clip ? {OUT_W{1'b1}} : acc_sum[OUT_W-1:0];

        if (en) begin
            out_valid_d = 1'b0;
            if (s2_valid_q) begin
                if (!s2_acc_q) begin
                    out_valid_d = 1'b1;
                    out_count_d = OUT_W'(s2_cnt_q);
                    out_sat_d   = 1'b0;
                end else if (!s2_last_q) begin
                    acc_d    = acc_sat;
                    sticky_d = sticky_base | clip;
                    state_d  = ACCUM;
                end else begin
                    out_valid_d = 1'b1;
                    out_count_d = acc_sat;
                    out_sat_d   = sticky_base | clip;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Accumulator, sticky clip flag and output registers.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_popcount_pipe.sv
// Scoreboard bench for popcount_pipe: two instances (OUT_W=16 and OUT_W=6)
// share all inputs; a reference model computes expected results from whole
// beat counts, and a negedge monitor checks every presented result.
module tb_popcount_pipe;

    localparam int W = 40;

    logic          clk = 1'b0;
    logic          RST;
    logic          in_valid;
    logic [W-1:0]  in_mask;
    logic          in_acc;
    logic          in_last;
    logic          out_ready;

    logic          in_ready,   in_ready_s;
    logic          out_valid,  out_valid_s;
    logic [15:0]   out_count;
    logic [5:0]    out_count_s;
    logic          out_sat,    out_sat_s;

    popcount_pipe #(.WIDTH(W), .OUT_W(16)) dut (
        .clk(clk), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
        .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_sat(out_sat)
    );

    popcount_pipe #(.WIDTH(W), .OUT_W(6)) dut_s (
        .clk(clk), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_mask(in_mask),
        .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_count(out_count_s), .out_sat(out_sat_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt16;
        bit sat16;
        int cnt6;
        bit sat6;
        int acc_edge;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_sum = 0;
    bit   strict_lat = 1'b0;

    bit          held_valid = 1'b0;
    logic [15:0] held_cnt;
    logic [5:0]  held_cnt_s;
    logic        held_sat, held_sat_s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: whole-beat popcounts, unbounded running sum, clip decided at close.
    task automatic model_accept(input logic [W-1:0] m, input logic a, input logic l, input int e);
        int   c;
        int   tot;
        exp_t x;
        c = $countones(m);
        if (!a) begin
            x = '{c, 1'b0, c, 1'b0, e};
            exp_q.push_back(x);
        end else if (!l) begin
            acc_sum += c;
        end else begin
            tot        = acc_sum + c;
            x.cnt16    = (tot > 65535) ? 65535 : tot;
            x.sat16    = (tot > 65535);
            x.cnt6     = (tot > 63) ? 63 : tot;
            x.sat6     = (tot > 63);
            x.acc_edge = e;
            exp_q.push_back(x);
            acc_sum = 0;
        end
    endtask

    // One cycle of stimulus, called at posedge+1; returns whether the beat transferred.
    task automatic step(input logic v, input logic [W-1:0] m, input logic a, input logic l,
                        output bit took);
        in_valid = v;
        in_mask  = m;
        in_acc   = a;
        in_last  = l;
        @(negedge clk);
        took = v && in_ready;
        if (took) model_accept(m, a, l, cyc + 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] m, input logic a, input logic l);
        bit took;
        int tries;
        tries = 0;
        do begin
            step(1'b1, m, a, l, took);
            tries++;
        end while (!took && tries < 50);
        if (!took) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: beat not accepted in %0d cycles", tries);
        end
    endtask

    task automatic idle(input int n);
        bit took;
        repeat (n) step(1'b0, '0, 1'b0, 1'b0, took);
    endtask

    // Asynchronous reset pulse; outputs must clear before any clock edge.
    task automatic do_reset();
        RST = 1'b0;
        exp_q.delete();
        acc_sum = 0;
        #1;
        check("rst_out_valid",   out_valid,   0);
        check("rst_out_count",   out_count,   0);
        check("rst_out_sat",     out_sat,     0);
        check("rst_out_valid_s", out_valid_s, 0);
        check("rst_out_count_s", out_count_s, 0);
        check("rst_out_sat_s",   out_sat_s,   0);
        @(posedge clk);
        #1;
        RST = 1'b1;
        check("post_rst_in_ready",   in_ready,   1);
        check("post_rst_in_ready_s", in_ready_s, 1);
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!RST) begin
            held_valid = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, (!out_valid || out_ready));
            check("valid_lockstep", out_valid_s, out_valid);
            if (held_valid) begin
                check("hold_valid",   out_valid,   1);
                check("hold_count",   out_count,   held_cnt);
                check("hold_sat",     out_sat,     held_sat);
                check("hold_count_s", out_count_s, held_cnt_s);
                check("hold_sat_s",   out_sat_s,   held_sat_s);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: out_count=%0d with nothing pending", out_count);
                end else begin
                    check("count16", out_count,   exp_q[0].cnt16);
                    check("sat16",   out_sat,     exp_q[0].sat16);
                    check("count6",  out_count_s, exp_q[0].cnt6);
                    check("sat6",    out_sat_s,   exp_q[0].sat6);
                    if (out_ready) begin
                        if (strict_lat) check("latency", cyc, exp_q[0].acc_edge + 2);
                        void'(exp_q.pop_front());
                    end
                end
            end
            held_valid = out_valid && !out_ready;
            held_cnt   = out_count;
            held_sat   = out_sat;
            held_cnt_s = out_count_s;
            held_sat_s = out_sat_s;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           took;
        logic [63:0]  r64;
        logic [W-1:0] pend;
        logic [W-1:0] m;
        int           waited;

        in_valid  = 1'b0;
        in_mask   = '0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        RST       = 1'b1;

        // Power-on reset, checked before any clock edge.
        #1;
        RST = 1'b0;
        #1;
        check("por_out_valid", out_valid, 0);
        check("por_out_count", out_count, 0);
        check("por_out_sat",   out_sat,   0);
        @(posedge clk);
        @(posedge clk);
        #1;
        RST = 1'b1;
        check("por_in_ready", in_ready, 1);

        // Back-to-back standalone beats: 0, 40, 20 with fixed two-edge latency.
        strict_lat = 1'b1;
        send('0, 1'b0, 1'b0);
        send('1, 1'b0, 1'b0);
        send(40'h55_5555_5555, 1'b0, 1'b0);
        idle(4);

        // Three-beat accumulation 40 + 7 + 13 = 60, single result.
        send('1, 1'b1, 1'b0);
        send(40'h7F, 1'b1, 1'b0);
        send(40'h1FFF, 1'b1, 1'b1);
        idle(5);
        check("acc3_drained", exp_q.size(), 0);
        check("valid_drops", out_valid, 0);
        strict_lat = 1'b0;

        // Output stall for 5 cycles with input held valid.
        r64  = {$urandom(), $urandom()};
        pend = r64[W-1:0];
        for (int i = 0; i < 16; i++) begin
            out_ready = (i < 2) || (i >= 7);
            step(1'b1, pend, 1'b0, 1'b0, took);
            if (i >= 3 && i <= 6) check("stall_in_ready", took, 0);
            if (took) begin
                r64  = {$urandom(), $urandom()};
                pend = r64[W-1:0];
            end
        end
        out_ready = 1'b1;
        idle(5);
        check("stall_drained", exp_q.size(), 0);

        // Open accumulation of 25, standalone 9 in between, close with 5 -> 9 then 30.
        send(40'h1FF_FFFF, 1'b1, 1'b0);
        send(40'h1FF, 1'b0, 1'b0);
        send(40'h1F, 1'b1, 1'b1);
        idle(5);

        // Saturation on the narrow instance, then a clean 3-bit accumulation.
        send('1, 1'b1, 1'b0);
        send('1, 1'b1, 1'b1);
        send(40'h7, 1'b1, 1'b1);
        idle(5);
        check("sat_drained", exp_q.size(), 0);

        // Reset during an accumulation with two beats in flight.
        send(40'hFF, 1'b1, 1'b0);
        send(40'hF0F, 1'b1, 1'b0);
        do_reset();
        send(40'h3F, 1'b1, 1'b1);
        idle(5);
        check("rst_acc_drained", exp_q.size(), 0);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            r64 = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0:       m = '0;
                1, 2:    m = '1;
                default: m = r64[W-1:0];
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 4) != 0), m, 1'(($urandom_range(0, 1))),
                 ($urandom_range(0, 2) == 0), took);
            if (i == 200) begin
                // Reset in the middle of a stall.
                out_ready = 1'b0;
                repeat (4) step(1'b1, '1, 1'b1, 1'b0, took);
                do_reset();
            end
        end

        // Drain everything still pending.
        out_ready = 1'b1;
        in_valid  = 1'b0;
        waited    = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            idle(1);
            waited++;
        end
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
